// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared types for the fetch/data memory arbiter
package unified_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      F_REQ  = 3'd1,
      F_WAIT = 3'd2,
      EXEC   = 3'd3,
      D_REQ  = 3'd4,
      D_WAIT = 3'd5,
      D_DONE = 3'd6
   } arb_state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } bus_req_t;

   localparam logic [3:0] STRB_ALL = 4'hF;

   // States in which the arbiter is waiting on the bus and may time out
   function automatic logic is_bus_wait(arb_state_t s);
      return s inside {F_REQ, F_WAIT, D_REQ, D_WAIT};
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_bus_timeout.sv
// rtl/unified_mem_arbiter_bus_timeout.sv - bus wait counter with clear/enable and expiry flag
module unified_mem_arbiter_bus_timeout #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   // A zero TIMEOUT_CYCLES wraps LIMIT harmlessly; expiry is gated off below
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: restart on state entry, otherwise advance while waiting
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - sequences core fetch and data accesses onto one memory bus
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] instruction,
   output logic        instr_valid,
   input  logic [31:0] address,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [31:0] write_data,
   input  logic [3:0]  strb,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        write_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_strb,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        bus_error
);

   arb_state_t  state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] rdata_q, rdata_d;
   bus_req_t    req_q, req_d;
   logic        timeout;

   unified_mem_arbiter_bus_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (state_d != state_q),
      .enable_i (is_bus_wait(state_q)),
      .expired_o(timeout)
   );

   // State register; reset abandons any bus transaction at once
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; a timeout force-completes the current bus phase
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = F_REQ;
         F_REQ:   if (timeout) state_d = EXEC; else if (mem_ready) state_d = F_WAIT;
         F_WAIT:  if (timeout || mem_rvalid) state_d = EXEC;
         EXEC:    state_d = (read_enable || write_enable) ? D_REQ : F_REQ;
         D_REQ:   if (timeout) state_d = D_DONE;
                  else if (mem_ready) state_d = req_q.we ? D_DONE : D_WAIT;
         D_WAIT:  if (timeout || mem_rvalid) state_d = D_DONE;
         D_DONE:  state_d = F_REQ;
         default: state_d = IDLE;
      endcase
   end

   // Buffer updates: instruction word, load data and the latched data request
   always_comb begin
      instr_d = instr_q;
      rdata_d = rdata_q;
      req_d   = req_q;
      case (state_q)
         F_REQ:   if (timeout) instr_d = '0;
         F_WAIT:  if (timeout) instr_d = '0; else if (mem_rvalid) instr_d = mem_rdata;
         EXEC: begin
            if (read_enable || write_enable) begin
               req_d.we    = write_enable;
               req_d.addr  = address;
               req_d.wdata = write_data;
               req_d.strb  = strb;
            end
         end
         D_REQ:   if (timeout && !req_q.we) rdata_d = '0;
         D_WAIT:  if (timeout) rdata_d = '0; else if (mem_rvalid) rdata_d = mem_rdata;
         default: ;
      endcase
   end

   // Buffer registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instr_q <= '0;
         rdata_q <= '0;
         req_q   <= '0;
      end else begin
         instr_q <= instr_d;
         rdata_q <= rdata_d;
         req_q   <= req_d;
      end
   end

   // Outputs from state and buffers only; pc passes through solely during F_REQ
   always_comb begin
      instr_valid = 1'b0;
      read_valid  = 1'b0;
      write_ready = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_strb    = '0;
      case (state_q)
         F_REQ: begin
            mem_req  = !timeout;
            mem_addr = pc;
            mem_strb = STRB_ALL;
         end
         EXEC:   instr_valid = 1'b1;
         D_REQ: begin
            instr_valid = 1'b1;
            mem_req     = !timeout;
            mem_we      = req_q.we;
            mem_addr    = req_q.addr;
            mem_wdata   = req_q.we ? req_q.wdata : '0;
            mem_strb    = req_q.we ? req_q.strb : STRB_ALL;
         end
         D_WAIT: instr_valid = 1'b1;
         D_DONE: begin
            instr_valid = 1'b1;
            read_valid  = !req_q.we;
            write_ready = req_q.we;
         end
         default: ;
      endcase
   end

   assign instruction = instr_q;
   assign read_data   = rdata_q;
   assign bus_error   = timeout;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

   logic        clock, reset;
   logic [31:0] pc, instruction, address, write_data, read_data;
   logic        instr_valid, read_enable, write_enable, read_valid, write_ready;
   logic [3:0]  strb, mem_strb;
   logic        mem_req, mem_we, mem_ready, mem_rvalid, bus_error;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   int          errors = 0;
   int          checks = 0;

   unified_mem_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
      .clock(clock), .reset(reset), .pc(pc), .instruction(instruction),
      .instr_valid(instr_valid), .address(address), .read_enable(read_enable),
      .write_enable(write_enable), .write_data(write_data), .strb(strb),
      .read_data(read_data), .read_valid(read_valid), .write_ready(write_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_strb(mem_strb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .bus_error(bus_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic do_reset(input logic [31:0] start_pc);
      reset = 1'b1; pc = start_pc; address = '0; read_enable = 1'b0; write_enable = 1'b0;
      write_data = '0; strb = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // Zero-wait fetch: returns at the negedge of the first instr_valid cycle
   task automatic fetch_word(input logic [31:0] word);
      int n = 0;
      @(negedge clock);
      while (!mem_req && n < 20) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (mem_req !== 1'b1) begin
         errors++;
         $display("FAIL fetch_req: mem_req=%b after %0d cycles, required 1", mem_req, n);
      end
      mem_ready = 1'b1;
      @(negedge clock);
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = word;
      @(negedge clock);
      mem_rvalid = 1'b0; mem_rdata = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1; pc = 32'h8000_0000; address = '0; read_enable = 1'b1; write_enable = 1'b1;
      write_data = '1; strb = '1; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = '1;
      repeat (2) @(negedge clock);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_strb, instr_valid, instruction,
           read_valid, write_ready, read_data, bus_error} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b we=%b addr=%h strb=%h iv=%b instr=%h rd=%h, required all 0",
                  mem_req, mem_we, mem_addr, mem_strb, instr_valid, instruction, read_data);
      end
      read_enable = 1'b0; write_enable = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      reset = 1'b0;
      checks++;
      if (mem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: mem_req=%b, required 0", mem_req);
      end
      @(negedge clock);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_strb} !== {1'b1, 1'b0, 32'h8000_0000, 4'hF}) begin
         errors++;
         $display("FAIL reset_first_fetch: req=%b we=%b addr=%h strb=%h, required 1 0 80000000 f",
                  mem_req, mem_we, mem_addr, mem_strb);
      end
   endtask

   task automatic test_alu;
      do_reset(32'h8000_0000);
      fetch_word(32'h0010_0093);
      checks++;
      if ({instr_valid, instruction, mem_req} !== {1'b1, 32'h0010_0093, 1'b0}) begin
         errors++;
         $display("FAIL alu_exec: iv=%b instr=%h req=%b, required 1 00100093 0",
                  instr_valid, instruction, mem_req);
      end
      pc = 32'h8000_0004;
      @(negedge clock);
      checks++;
      if ({mem_req, mem_we, mem_addr, instr_valid} !== {1'b1, 1'b0, 32'h8000_0004, 1'b0}) begin
         errors++;
         $display("FAIL alu_next_fetch: req=%b we=%b addr=%h iv=%b, required 1 0 80000004 0",
                  mem_req, mem_we, mem_addr, instr_valid);
      end
   endtask

   task automatic test_load;
      do_reset(32'h8000_0010);
      fetch_word(32'h0000_2083);
      read_enable = 1'b1; address = 32'h8000_0100;
      @(negedge clock);
      read_enable = 1'b0; address = 32'h0;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_strb, instr_valid} !== {1'b1, 1'b0, 32'h8000_0100, 4'hF, 1'b1}) begin
         errors++;
         $display("FAIL load_req: req=%b we=%b addr=%h strb=%h iv=%b, required 1 0 80000100 f 1",
                  mem_req, mem_we, mem_addr, mem_strb, instr_valid);
      end
      mem_ready = 1'b1;
      @(negedge clock);
      mem_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if ({instr_valid, mem_req, read_valid, instruction} !== {1'b1, 1'b0, 1'b0, 32'h0000_2083}) begin
            errors++;
            $display("FAIL load_wait%0d: iv=%b req=%b rv=%b instr=%h, required 1 0 0 00002083",
                     c, instr_valid, mem_req, read_valid, instruction);
         end
         @(negedge clock);
      end
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clock);
      mem_rvalid = 1'b0; mem_rdata = 32'h1234_5678;
      checks++;
      if ({read_valid, read_data, instr_valid, instruction} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_2083}) begin
         errors++;
         $display("FAIL load_done: rv=%b rdata=%h iv=%b instr=%h, required 1 deadbeef 1 00002083",
                  read_valid, read_data, instr_valid, instruction);
      end
      pc = 32'h8000_0014;
      @(negedge clock);
      checks++;
      if ({read_valid, instr_valid, mem_req, mem_addr, read_data} !== {1'b0, 1'b0, 1'b1, 32'h8000_0014, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL load_after: rv=%b iv=%b req=%b addr=%h rdata=%h, required 0 0 1 80000014 deadbeef",
                  read_valid, instr_valid, mem_req, mem_addr, read_data);
      end
   endtask

   task automatic test_store;
      do_reset(32'h8000_0020);
      fetch_word(32'h0020_A023);
      write_enable = 1'b1; read_enable = 1'b1;
      address = 32'h8000_0200; write_data = 32'h0000_1234; strb = 4'b0011;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         write_enable = 1'($urandom); read_enable = 1'($urandom);
         address = $urandom; write_data = $urandom; strb = 4'($urandom);
         checks++;
         if ({mem_req, mem_we, mem_addr, mem_wdata, mem_strb, instr_valid, write_ready}
             !== {1'b1, 1'b1, 32'h8000_0200, 32'h0000_1234, 4'b0011, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL store_req%0d: req=%b we=%b addr=%h wdata=%h strb=%b iv=%b wr=%b, required 1 1 80000200 00001234 0011 1 0",
                     c, mem_req, mem_we, mem_addr, mem_wdata, mem_strb, instr_valid, write_ready);
         end
         mem_ready = (c == 3);
      end
      @(negedge clock);
      mem_ready = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
      checks++;
      if ({write_ready, read_valid, mem_req, instr_valid} !== {1'b1, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL store_done: wr=%b rv=%b req=%b iv=%b, required 1 0 0 1",
                  write_ready, read_valid, mem_req, instr_valid);
      end
      pc = 32'h8000_0024;
      @(negedge clock);
      checks++;
      if ({write_ready, instr_valid, mem_req, mem_addr} !== {1'b0, 1'b0, 1'b1, 32'h8000_0024}) begin
         errors++;
         $display("FAIL store_after: wr=%b iv=%b req=%b addr=%h, required 0 0 1 80000024",
                  write_ready, instr_valid, mem_req, mem_addr);
      end
   endtask

   task automatic test_timeout;
      do_reset(32'h8000_0030);
      fetch_word(32'h0010_0093);
      pc = 32'h8000_0034;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clock);
         checks++;
         if ({mem_req, bus_error, instr_valid} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_wait%0d: req=%b err=%b iv=%b, required 1 0 0",
                     c, mem_req, bus_error, instr_valid);
         end
      end
      @(negedge clock);
      checks++;
      if ({bus_error, instr_valid} !== {1'b1, 1'b0}) begin
         errors++;
         $display("FAIL timeout_pulse: err=%b iv=%b, required 1 0", bus_error, instr_valid);
      end
      @(negedge clock);
      checks++;
      if ({instr_valid, instruction, bus_error, mem_req} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL timeout_deliver: iv=%b instr=%h err=%b req=%b, required 1 00000000 0 0",
                  instr_valid, instruction, bus_error, mem_req);
      end
   endtask

   task automatic test_reset_mid;
      do_reset(32'h8000_0040);
      fetch_word(32'h0000_2083);
      read_enable = 1'b1; address = 32'h8000_0100;
      @(negedge clock);
      read_enable = 1'b0; mem_ready = 1'b1;
      @(negedge clock);
      mem_ready = 1'b0;
      checks++;
      if ({instr_valid, mem_req} !== {1'b1, 1'b0}) begin
         errors++;
         $display("FAIL midrst_dwait: iv=%b req=%b, required 1 0", instr_valid, mem_req);
      end
      #2;
      reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_strb, instr_valid, instruction,
           read_valid, write_ready, read_data, bus_error} !== '0) begin
         errors++;
         $display("FAIL midrst_async: req=%b addr=%h iv=%b instr=%h rv=%b rd=%h, required all 0",
                  mem_req, mem_addr, instr_valid, instruction, read_valid, read_data);
      end
      repeat (2) @(negedge clock);
      pc = 32'h8000_0080;
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({mem_req, mem_addr, mem_we, instr_valid, read_valid, read_data}
          !== {1'b1, 32'h8000_0080, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL midrst_refetch: req=%b addr=%h we=%b iv=%b rv=%b rd=%h, required 1 80000080 0 0 0 0",
                  mem_req, mem_addr, mem_we, instr_valid, read_valid, read_data);
      end
      @(negedge clock);
      mem_rvalid = 1'b0;
      checks++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h8000_0080, 1'b0}) begin
         errors++;
         $display("FAIL midrst_stale: req=%b addr=%h iv=%b, required 1 80000080 0",
                  mem_req, mem_addr, instr_valid);
      end
      fetch_word(32'h0000_0013);
      checks++;
      if ({instr_valid, instruction} !== {1'b1, 32'h0000_0013}) begin
         errors++;
         $display("FAIL midrst_resume: iv=%b instr=%h, required 1 00000013", instr_valid, instruction);
      end
   endtask

   // Random core and random-latency memory; scoreboard at instruction/transaction level
   task automatic test_random;
      logic [31:0] mem [64];
      logic [31:0] exp_instr, exp_rdata, rd_data, d_addr, d_wdata;
      logic [3:0]  d_strb;
      int op = 0;
      bit want_data = 0, req_waiting = 0, rd_pending = 0, rd_fetch = 0;
      bit prev_iv = 0, exp_rv = 0, exp_wr = 0;
      int req_wait = 0, rv_wait = 0, cycles = 0, commits = 0, fetches = 0;
      int loads = 0, stores = 0, rv_seen = 0, wr_seen = 0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      exp_instr = '0; exp_rdata = '0; rd_data = '0; d_addr = '0; d_wdata = '0; d_strb = '0;
      do_reset(32'h8000_0000);
      while (commits < 1000 && cycles < 40000) begin
         @(negedge clock);
         cycles++;
         checks++;
         if ({read_valid, write_ready, bus_error} !== {exp_rv, exp_wr, 1'b0}) begin
            errors++;
            $display("FAIL rand_pulses: rv/wr/err=%b%b%b, required %b%b0 at cycle %0d",
                     read_valid, write_ready, bus_error, exp_rv, exp_wr, cycles);
         end
         exp_rv = 0; exp_wr = 0;
         if (read_valid === 1'b1) begin
            rv_seen++;
            checks++;
            if (read_data !== exp_rdata) begin
               errors++;
               $display("FAIL rand_rdata: read_data=%h, required %h", read_data, exp_rdata);
            end
         end
         if (write_ready === 1'b1) wr_seen++;
         if (read_valid === 1'b1 || write_ready === 1'b1) begin
            commits++;
            pc = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
         end
         if (rd_pending) begin
            checks++;
            if (mem_req !== 1'b0) begin
               errors++;
               $display("FAIL rand_overlap: mem_req=%b while a read is outstanding, required 0", mem_req);
            end
         end
         mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (instr_valid === 1'b1 && !prev_iv) begin
            checks++;
            if ({instruction, mem_req} !== {exp_instr, 1'b0}) begin
               errors++;
               $display("FAIL rand_instr: instr=%h req=%b, required %h 0", instruction, mem_req, exp_instr);
            end
            op = $urandom_range(0, 2);
            d_addr = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
            d_wdata = $urandom; d_strb = 4'($urandom);
            read_enable = (op == 1) || (op == 2 && $urandom_range(0, 1) == 1);
            write_enable = (op == 2);
            address = d_addr; write_data = d_wdata; strb = d_strb;
            if (op == 0) begin
               commits++;
               pc = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
            end else begin
               want_data = 1;
            end
         end else begin
            read_enable = 1'($urandom); write_enable = 1'($urandom);
            address = $urandom; write_data = $urandom; strb = 4'($urandom);
         end
         if (rd_pending) begin
            if (rv_wait == 0) begin
               mem_rvalid = 1'b1; mem_rdata = rd_data; rd_pending = 0;
               if (rd_fetch) exp_instr = rd_data; else exp_rv = 1;
            end else begin
               rv_wait--;
            end
         end
         if (mem_req === 1'b1) begin
            if (!req_waiting) begin
               req_waiting = 1;
               req_wait = $urandom_range(0, 5);
            end
            if (req_wait == 0) begin
               mem_ready = 1'b1; req_waiting = 0;
               checks++;
               if (!want_data) begin
                  fetches++;
                  if ({mem_we, mem_addr, mem_strb} !== {1'b0, pc, 4'hF}) begin
                     errors++;
                     $display("FAIL rand_fetch: we=%b addr=%h strb=%h, required 0 %h f", mem_we, mem_addr, mem_strb, pc);
                  end
                  rd_pending = 1; rd_fetch = 1; rd_data = mem[pc[7:2]];
                  rv_wait = $urandom_range(0, 4);
               end else begin
                  want_data = 0;
                  if (op == 2) begin
                     stores++;
                     if ({mem_we, mem_addr, mem_wdata, mem_strb} !== {1'b1, d_addr, d_wdata, d_strb}) begin
                        errors++;
                        $display("FAIL rand_store: we=%b addr=%h wdata=%h strb=%h, required 1 %h %h %h",
                                 mem_we, mem_addr, mem_wdata, mem_strb, d_addr, d_wdata, d_strb);
                     end
                     for (int b = 0; b < 4; b++)
                        if (d_strb[b]) mem[d_addr[7:2]][8*b +: 8] = d_wdata[8*b +: 8];
                     exp_wr = 1;
                  end else begin
                     loads++;
                     if ({mem_we, mem_addr, mem_strb} !== {1'b0, d_addr, 4'hF}) begin
                        errors++;
                        $display("FAIL rand_load: we=%b addr=%h strb=%h, required 0 %h f",
                                 mem_we, mem_addr, mem_strb, d_addr);
                     end
                     rd_pending = 1; rd_fetch = 0; rd_data = mem[d_addr[7:2]];
                     exp_rdata = rd_data; rv_wait = $urandom_range(0, 4);
                  end
               end
            end else begin
               req_wait--;
            end
         end
         prev_iv = (instr_valid === 1'b1);
      end
      read_enable = 1'b0; write_enable = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      checks++;
      if (commits < 1000) begin
         errors++;
         $display("FAIL rand_progress: %0d commits in %0d cycles, required 1000", commits, cycles);
      end
      checks++;
      if (fetches != commits) begin
         errors++;
         $display("FAIL rand_fetch_count: %0d fetches, required %0d", fetches, commits);
      end
      checks++;
      if (rv_seen != loads || wr_seen != stores) begin
         errors++;
         $display("FAIL rand_pulse_count: read_valid=%0d write_ready=%0d, required %0d %0d",
                  rv_seen, wr_seen, loads, stores);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
